// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed seven-segment scanner with blanking guard and frame-aligned double buffer
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-low
//   enable     1 = scan running, 0 = display dark
//   load       strobe capturing Data_in/dp_in into the pending buffer
//   Data_in    hex nibbles, digit 0 in the low nibble
//   dp_in      decimal point request per digit, 1 = lit
//   ready      1 = pending buffer empty
//   outDisplay segments {g,f,e,d,c,b,a}, active-low
//   dp         decimal point, active-low
//   an         anode enables, active-low, at most one low
//   digit_idx  index of the selected digit
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          load,
    input  logic [4*NUM_DIGITS-1:0]       Data_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    output logic                          ready,
    output logic [6:0]                    outDisplay,
    output logic                          dp,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [6:0] SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
    // Slot entry state: blanking phase is skipped entirely when BLANK_CYCLES is 0
    localparam state_t FIRST = (BLANK_CYCLES > 0) ? BLANK : SHOW;
    state_t                  st, st_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [IW-1:0]           idx_n;
    logic [4*NUM_DIGITS-1:0] act, act_n, pend, pend_n;
    logic [NUM_DIGITS-1:0]   act_dp, act_dp_n, pend_dp, pend_dp_n;
    logic                    pv, pv_n, wrap, xfer;
    always_comb begin
        st_n  = st;
        cnt_n = cnt + 1'b1;
        idx_n = digit_idx;
        wrap  = 1'b0;
        if (!enable) begin
            st_n  = IDLE;
            cnt_n = '0;
            idx_n = '0;
        end else begin
            case (st)
                IDLE: begin
                    st_n  = FIRST;
                    cnt_n = '0;
                    idx_n = '0;
                end
                BLANK: begin
                    if (cnt == CW'(BLANK_CYCLES - 1)) begin
                        st_n  = SHOW;
                        cnt_n = '0;
                    end
                end
                default: begin
                    if (cnt == CW'(REFRESH_DIV - BLANK_CYCLES - 1)) begin
                        st_n  = FIRST;
                        cnt_n = '0;
                        wrap  = digit_idx == IW'(NUM_DIGITS - 1);
                        idx_n = wrap ? '0 : digit_idx + 1'b1;
                    end
                end
            endcase
        end
        // Transfer uses the old pending word; a load on the same edge stays pending
        xfer      = pv && (st == IDLE || wrap);
        act_n     = xfer ? pend : act;
        act_dp_n  = xfer ? pend_dp : act_dp;
        pend_n    = load ? Data_in : pend;
        pend_dp_n = load ? dp_in : pend_dp;
        pv_n      = load || (pv && !xfer);
    end
    // Outputs are registered from next-state values so they align with the state they describe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st         <= IDLE;
            cnt        <= '0;
            digit_idx  <= '0;
            act        <= '0;
            act_dp     <= '0;
            pend       <= '0;
            pend_dp    <= '0;
            pv         <= 1'b0;
            ready      <= 1'b1;
            an         <= '1;
            outDisplay <= 7'h7F;
            dp         <= 1'b1;
        end else begin
            st         <= st_n;
            cnt        <= cnt_n;
            digit_idx  <= idx_n;
            act        <= act_n;
            act_dp     <= act_dp_n;
            pend       <= pend_n;
            pend_dp    <= pend_dp_n;
            pv         <= pv_n;
            ready      <= !pv_n;
            an         <= (st_n == SHOW) ? ~(NUM_DIGITS'(1) << idx_n) : '1;
            outDisplay <= (st_n == IDLE) ? 7'h7F : SEG[act_n[{idx_n, 2'b00} +: 4]];
            dp         <= (st_n == IDLE) || !act_dp_n[idx_n];
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed self-checking bench for seg_scan_ctrl with an 8-cycle slot and 2 blank cycles
module tb_seg_scan_ctrl;
    logic        clk = 0, rst = 0, enable = 0, load = 0;
    logic [15:0] data = 0;
    logic [3:0]  dp_in = 0;
    logic        ready, dp;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [1:0]  idx;
    int          checks = 0, errors = 0, cyc = 0;
    logic [6:0]  pat [4] = '{7'h40, 7'h00, 7'h03, 7'h79};

    seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .Data_in(data), .dp_in(dp_in),
        .ready(ready), .outDisplay(seg), .dp(dp), .an(an), .digit_idx(idx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        checks++;
        if (!$onehot0(~an)) begin
            errors++;
            $display("FAIL onehot_an: an=%b has more than one anode low", an);
        end
    end

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic advance(input int n);
        while (cyc < n) step();
    endtask

    task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
        data = d; dp_in = p; load = 1;
        step();
        load = 0;
    endtask

    task automatic start_scan();
        enable = 0;
        step();
        enable = 1;
        step();
        cyc = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({an, seg, dp, ready, idx} !== {4'hF, 7'h7F, 1'b1, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL reset: an=%b seg=%h dp=%b ready=%b idx=%0d, want 1111 7f 1 1 0", an, seg, dp, ready, idx);
        end
        rst = 1;
        step();
    endtask

    task automatic test_scan();
        pulse_load(16'h1B80, 4'b0000);
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL scan_ready_low: ready=%b want 0", ready); end
        enable = 1;
        step();
        cyc = 0;
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL scan_idle_xfer: ready=%b want 1", ready); end
        for (int c = 0; c <= 32; c++) begin
            int s;
            logic [3:0] ae;
            if (c > 0) step();
            s  = (c / 8) % 4;
            ae = (c % 8 < 2) ? 4'hF : ~(4'b0001 << s);
            checks++;
            if ({an, seg, idx} !== {ae, pat[s], 2'(s)}) begin
                errors++;
                $display("FAIL scan c=%0d: an=%b seg=%b idx=%0d want %b %b %0d", c, an, seg, idx, ae, pat[s], s);
            end
        end
    endtask

    task automatic test_frame_update();
        start_scan();
        advance(12);
        pulse_load(16'hFFFF, 4'b0000);
        checks++;
        if ({ready, seg} !== {1'b0, 7'h00}) begin
            errors++; $display("FAIL frame_mid: ready=%b seg=%b want 0 0000000", ready, seg);
        end
        advance(31);
        checks++;
        if ({ready, seg} !== {1'b0, 7'h79}) begin
            errors++; $display("FAIL frame_last_old: ready=%b seg=%b want 0 1111001", ready, seg);
        end
        step();
        checks++;
        if ({ready, seg, an, idx} !== {1'b1, 7'h0E, 4'hF, 2'd0}) begin
            errors++; $display("FAIL frame_wrap: ready=%b seg=%b an=%b idx=%0d want 1 0001110 1111 0", ready, seg, an, idx);
        end
        advance(34);
        checks++;
        if ({an, seg} !== {4'b1110, 7'h0E}) begin
            errors++; $display("FAIL frame_new_show: an=%b seg=%b want 1110 0001110", an, seg);
        end
    endtask

    task automatic test_overwrite();
        start_scan();
        advance(3);
        pulse_load(16'h1111, 4'b0000);
        advance(10);
        pulse_load(16'h8888, 4'b0000);
        advance(31);
        checks++;
        if ({ready, seg} !== {1'b0, 7'h0E}) begin
            errors++; $display("FAIL ovr_before_wrap: ready=%b seg=%b want 0 0001110", ready, seg);
        end
        pulse_load(16'h0000, 4'b0000);
        checks++;
        if ({ready, seg} !== {1'b0, 7'h00}) begin
            errors++; $display("FAIL ovr_wrap_same_edge: ready=%b seg=%b want 0 0000000", ready, seg);
        end
        advance(42);
        checks++;
        if ({an, seg} !== {4'b1101, 7'h00}) begin
            errors++; $display("FAIL ovr_digit1: an=%b seg=%b want 1101 0000000", an, seg);
        end
        advance(63);
        checks++;
        if ({ready, seg} !== {1'b0, 7'h00}) begin
            errors++; $display("FAIL ovr_digit3: ready=%b seg=%b want 0 0000000", ready, seg);
        end
        step();
        checks++;
        if ({ready, seg} !== {1'b1, 7'h40}) begin
            errors++; $display("FAIL ovr_late_load: ready=%b seg=%b want 1 1000000", ready, seg);
        end
    endtask

    task automatic test_enable_drop();
        start_scan();
        advance(15);
        pulse_load(16'h0B00, 4'b0000);
        advance(18);
        checks++;
        if ({an, seg} !== {4'b1011, 7'h40}) begin
            errors++; $display("FAIL drop_pre: an=%b seg=%b want 1011 1000000", an, seg);
        end
        enable = 0;
        step();
        checks++;
        if ({an, seg, dp, idx, ready} !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
            errors++; $display("FAIL drop_dark: an=%b seg=%b dp=%b idx=%0d ready=%b want 1111 7f 1 0 0", an, seg, dp, idx, ready);
        end
        step();
        checks++;
        if ({an, ready} !== {4'hF, 1'b1}) begin
            errors++; $display("FAIL drop_idle_xfer: an=%b ready=%b want 1111 1", an, ready);
        end
        enable = 1;
        step();
        cyc = 0;
        checks++;
        if ({an, seg, idx} !== {4'hF, 7'h40, 2'd0}) begin
            errors++; $display("FAIL drop_restart: an=%b seg=%b idx=%0d want 1111 1000000 0", an, seg, idx);
        end
        advance(2);
        checks++;
        if (an !== 4'b1110) begin errors++; $display("FAIL drop_digit0: an=%b want 1110", an); end
        advance(18);
        checks++;
        if ({an, seg} !== {4'b1011, 7'h03}) begin
            errors++; $display("FAIL drop_kept_pending: an=%b seg=%b want 1011 0000011", an, seg);
        end
    endtask

    task automatic test_dp();
        enable = 0;
        step();
        pulse_load(16'h1B80, 4'b0100);
        enable = 1;
        step();
        cyc = 0;
        for (int c = 0; c < 32; c++) begin
            logic de;
            if (c > 0) step();
            de = ((c / 8) == 2) ? 1'b0 : 1'b1;
            checks++;
            if (dp !== de) begin errors++; $display("FAIL dp c=%0d: dp=%b want %b", c, dp, de); end
        end
    endtask

    task automatic test_reset_mid();
        start_scan();
        advance(19);
        pulse_load(16'h8888, 4'b1111);
        #2;
        rst = 0;
        #1;
        checks++;
        if ({an, seg, dp, ready, idx} !== {4'hF, 7'h7F, 1'b1, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL reset_mid: an=%b seg=%h dp=%b ready=%b idx=%0d want 1111 7f 1 1 0", an, seg, dp, ready, idx);
        end
        enable = 0;
        @(negedge clk);
        rst = 1;
        start_scan();
        advance(10);
        checks++;
        if ({an, seg, dp, ready} !== {4'b1101, 7'h40, 1'b1, 1'b1}) begin
            errors++; $display("FAIL reset_cleared: an=%b seg=%b dp=%b ready=%b want 1101 1000000 1 1", an, seg, dp, ready);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_frame_update();
        test_overwrite();
        test_enable_drop();
        test_dp();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
